aes_key_sched_ctrl: RTL and testbench
=====================================

# aes_key_sched_ctrl

Sequencer that expands a 128- or 256-bit AES key into the full round-key set using the shared single-lane round-key generator (`roundkeygen_1lane`). It owns the sliding word window, Rcon indexing and the AES-128 Rcon extension. It stores the 11 or 15 round keys in a local register file, and the cipher datapath reads them back through a registered read port.

## Interface

- No parameters; all sizes are fixed by the AES standard.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- key_in  in  256  cipher key, MSB-first; AES-128 uses key_in[255:128]
- key_mode  in  1  0 = AES-128, 1 = AES-256; sampled with key_load
- key_load  in  1  single-cycle pulse that starts expansion; ignored while busy
- busy  out  1  expansion in progress
- key_ready  out  1  all round keys valid; held high until the next key_load or key_clear
- gen_w0..gen_w7  out  32 each  window driven to the generator
- gen_rcon_idx  out  3  Rcon index to the generator
- gen_use_rcon  out  1  RotWord+Rcon enable to the generator
- gen_start  out  1  single-cycle start pulse
- gen_w8..gen_w11  in  32 each  generator result
- gen_done  in  1  generator result valid
- rk_rd_en  in  1  read strobe
- rk_rd_idx  in  4  round index, 0..14
- rk_rd_data  out  128  round key {w0,w1,w2,w3}
- key_clear  in  1  zeroize pulse; present only with AES_KEYSCHED_ZEROIZE_EN

## Operation

- **Reset values.** All outputs are 0, the register file is 0, and the FSM is in IDLE.
- **FSM states:** IDLE, START, WAIT, DRAIN.
- **IDLE, on key_load:**
  - Latch key_mode.
  - Load the window: w0..w7 = key words.
  - Write rk0 = key[255:128].
  - For AES-256, also write rk1 = key[127:0].
  - Clear the quartet counter q.
  - Drop key_ready, raise busy, go to START.
- **START.** gen_start = 1 for exactly one cycle, then go to WAIT.
- **WAIT, on gen_done:**
  - Write {gen_w8..gen_w11} to rk[q+1] (AES-128) or rk[q+2] (AES-256).
  - Slide the window.
  - q++.
  - If q reaches the last quartet (9 for AES-128, 12 for AES-256), go to IDLE with key_ready = 1 and busy = 0. Otherwise go to START.
- **Generator outputs are ignored.** gen_rcon_idx_out and gen_use_rcon_out are not used; the controller derives Rcon itself from q.
- **AES-256 window and Rcon:**
  - gen_w0..w7 = current 8-word window.
  - gen_use_rcon = ~q[0].
  - gen_rcon_idx = q >> 1.
  - Slide: w0..w3 ← w4..w7, w4..w7 ← result.
- **AES-128 window:** gen_w0..w3 = current round key, and gen_w4..w7 carry the same four words.
- **AES-128 Rcon:**
  - gen_use_rcon = 1 for every quartet.
  - For q ≤ 7, gen_rcon_idx = q.
  - For q = 8 and q = 9 the generator's Rcon table is exhausted. Drive gen_rcon_idx = 0, and XOR gen_w0 with {RCON_FIX, 24'h0}, where RCON_FIX = 8'h1A (q = 8) and 8'h37 (q = 9). This yields the effective Rcon values 8'h1B and 8'h36.
- **Read port:**
  - rk_rd_data is registered and valid the cycle after rk_rd_en.
  - rk_rd_idx > 14, or beyond the last round of the latched mode, returns 0.
  - Reads during busy return the current file contents, including partially written entries.
- **Boundary cases:**
  - key_load while busy (including in DRAIN) is ignored.
  - key_load while key_ready restarts expansion; key_ready falls the next cycle.
  - Reset mid-expansion returns the block to IDLE with everything zero. The generator is reset by the same rst_n.

## Timing

- The generator's latency is 9 cycles: gen_start in cycle c gives gen_done in cycle c+9.
- One quartet takes 10 cycles: START plus 9 WAIT cycles. START follows gen_done directly.
- With key_load in cycle 0:
  - AES-128: the last gen_done arrives in cycle 100 and key_ready is high from cycle 101.
  - AES-256: the last gen_done arrives in cycle 130 and key_ready is high from cycle 131.
- The controller never asserts gen_start in two consecutive cycles.
- The controller never asserts gen_start while a quartet is outstanding.

## Configuration

- **AES_KEYSCHED_ZEROIZE_EN defined:**
  - The key_clear port exists.
  - A key_clear pulse zeroes the whole register file and the window in one cycle and drops key_ready and the read data.
  - If a quartet is outstanding, the FSM enters DRAIN, waits for gen_done, discards the result, then returns to IDLE. busy stays high during DRAIN.
  - key_clear takes priority over a simultaneous gen_done or key_load.
- **AES_KEYSCHED_ZEROIZE_EN not defined:** the port is absent, the DRAIN state is not built, and round keys persist until they are overwritten.

## Structure

- **aes_pkg** holds:
  - NR128 = 10 and NR256 = 14
  - the last-quartet constants 9 and 12
  - RCON_FIX_Q8 = 8'h1A and RCON_FIX_Q9 = 8'h37
  - the FSM state enum
- **aes_rk_file** is a sub-module: a 15 × 128 register file with one write port, a registered read port, and a clear-all input. The clear-all input is tied low when zeroize is not built.

## Test plan

- **AES-128 full expansion.** Load key 2b7e151628aed2a6abf7158809cf4f3c at cycle 0.
  - key_ready is high at cycle 101.
  - rk1 = a0fafe1788542cb123a339392a6c7605.
  - rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6, which also checks the q = 8/9 Rcon fix.
- **AES-256 full expansion.** Load key 603deb10…0914dff4 (FIPS-197 A.3).
  - key_ready is high at cycle 131.
  - rk14 = fe4890d1e6188d0b046df344706c631e.
- **key_load during busy.** Pulse key_load at cycle 40 of an AES-128 run: it is ignored and the result is identical to the first test.
- **Read-port bounds.** With the AES-128 key loaded:
  - reading idx 11 and idx 15 returns 0 the next cycle;
  - reading idx 0 returns the key itself.
- **Zeroize mid-run (macro on).** Pulse key_clear at cycle 25.
  - The FSM enters DRAIN and returns to IDLE at the next gen_done.
  - All reads return 0 and key_ready stays 0.
  - A subsequent key_load produces the correct keys.
- **Reset mid-run.** Assert rst_n = 0 at cycle 55: all outputs and reads are 0, then a fresh AES-256 load completes normally.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants and FSM state type for the AES key-schedule controller.
// AES_KEYSCHED_ZEROIZE_EN adds the DRAIN state used by key zeroization.
package aes_pkg;

  localparam int unsigned NR128 = 10;
  localparam int unsigned NR256 = 14;

  localparam logic [3:0] LAST_Q128 = 4'd9;
  localparam logic [3:0] LAST_Q256 = 4'd12;

  // The generator's Rcon table stops at 8'h80; XORing these into w0 with
  // rcon index 0 (8'h01) produces the effective 8'h1B and 8'h36.
  localparam logic [7:0] RCON_FIX_Q8 = 8'h1A;
  localparam logic [7:0] RCON_FIX_Q9 = 8'h37;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
`ifdef AES_KEYSCHED_ZEROIZE_EN
    ,
    ST_DRAIN = 2'd3
`endif
  } ks_state_e;

  // Highest round-key index that is valid for the given mode.
  function automatic logic [3:0] last_rk_idx(input logic mode);
    return mode ? 4'(NR256) : 4'(NR128);
  endfunction

  // Quartet index whose result completes the schedule.
  function automatic logic [3:0] last_quartet(input logic mode);
    return mode ? LAST_Q256 : LAST_Q128;
  endfunction

endpackage

// File: rtl/aes_rk_file.sv
// 15 x 128-bit round-key register file: one write port, a registered
// read port with range masking, and a single-cycle clear-all.
module aes_rk_file
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [3:0]   wr_idx,
  input  logic [127:0] wr_data,
  input  logic         rd_en,
  input  logic [3:0]   rd_idx,
  input  logic [3:0]   rd_last,
  input  logic         clear_all,
  output logic [127:0] rd_data
);

  logic [127:0] mem [15];

  // Storage: clear-all wins over a write in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '{default: '0};
    end else if (clear_all) begin
      mem <= '{default: '0};
    end else if (wr_en && (wr_idx <= 4'd14)) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Registered read; indices past the active mode's last round read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (clear_all) begin
      rd_data <= '0;
    end else if (rd_en) begin
      if ((rd_idx <= 4'd14) && (rd_idx <= rd_last)) begin
        rd_data <= mem[rd_idx];
      end else begin
        rd_data <= '0;
      end
    end
  end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128/256 key-expansion sequencer driving the shared single-lane
// round-key generator and filling the local round-key file.
// AES_KEYSCHED_ZEROIZE_EN adds key_clear and the DRAIN state.
module aes_key_sched_ctrl
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] key_in,
  input  logic         key_mode,
  input  logic         key_load,
  output logic         busy,
  output logic         key_ready,
  output logic [31:0]  gen_w0,
  output logic [31:0]  gen_w1,
  output logic [31:0]  gen_w2,
  output logic [31:0]  gen_w3,
  output logic [31:0]  gen_w4,
  output logic [31:0]  gen_w5,
  output logic [31:0]  gen_w6,
  output logic [31:0]  gen_w7,
  output logic [2:0]   gen_rcon_idx,
  output logic         gen_use_rcon,
  output logic         gen_start,
  input  logic [31:0]  gen_w8,
  input  logic [31:0]  gen_w9,
  input  logic [31:0]  gen_w10,
  input  logic [31:0]  gen_w11,
  input  logic         gen_done,
  input  logic         rk_rd_en,
  input  logic [3:0]   rk_rd_idx,
  output logic [127:0] rk_rd_data
`ifdef AES_KEYSCHED_ZEROIZE_EN
  ,
  input  logic         key_clear
`endif
);

  ks_state_e        state;
  logic             mode;
  logic [3:0]       q;
  logic [0:7][31:0] win;
  logic [127:0]     result;
  logic             clear;
  logic             wr_en;
  logic [3:0]       wr_idx;
  logic [127:0]     wr_data;

`ifdef AES_KEYSCHED_ZEROIZE_EN
  assign clear = key_clear;
`else
  assign clear = 1'b0;
`endif

  assign result = {gen_w8, gen_w9, gen_w10, gen_w11};

  // Sequencer: load, launch one quartet at a time, slide the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mode      <= 1'b0;
      q         <= '0;
      win       <= '0;
      busy      <= 1'b0;
      key_ready <= 1'b0;
      gen_start <= 1'b0;
    end else begin
      gen_start <= 1'b0;
`ifdef AES_KEYSCHED_ZEROIZE_EN
      if (clear) begin
        win       <= '0;
        q         <= '0;
        key_ready <= 1'b0;
        // A quartet launched in START or still pending must be drained;
        // a result arriving this very cycle is simply discarded.
        if ((state == ST_START) ||
            (((state == ST_WAIT) || (state == ST_DRAIN)) && !gen_done)) begin
          state <= ST_DRAIN;
          busy  <= 1'b1;
        end else begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      end else
`endif
      begin
        case (state)
          ST_IDLE: begin
            if (key_load) begin
              mode      <= key_mode;
              win       <= key_in;
              q         <= '0;
              key_ready <= 1'b0;
              busy      <= 1'b1;
              gen_start <= 1'b1;
              state     <= ST_START;
            end
          end
          ST_START: begin
            state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (gen_done) begin
              if (mode) begin
                win <= {win[4:7], result};
              end else begin
                win <= {result, result};
              end
              q <= q + 4'd1;
              if (q == last_quartet(mode)) begin
                state     <= ST_IDLE;
                busy      <= 1'b0;
                key_ready <= 1'b1;
              end else begin
                state     <= ST_START;
                gen_start <= 1'b1;
              end
            end
          end
`ifdef AES_KEYSCHED_ZEROIZE_EN
          ST_DRAIN: begin
            if (gen_done) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
`endif
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Generator window and Rcon selection derived from the quartet counter.
  always_comb begin
    gen_w0 = win[0];
    gen_w1 = win[1];
    gen_w2 = win[2];
    gen_w3 = win[3];
    if (mode) begin
      {gen_w4, gen_w5, gen_w6, gen_w7} = win[4:7];
    end else begin
      {gen_w4, gen_w5, gen_w6, gen_w7} = win[0:3];
    end
    gen_rcon_idx = '0;
    gen_use_rcon = 1'b0;
    if (busy) begin
      if (mode) begin
        gen_use_rcon = ~q[0];
        gen_rcon_idx = q[3:1];
      end else begin
        gen_use_rcon = 1'b1;
        if (q == 4'd8) begin
          gen_w0 = win[0] ^ {RCON_FIX_Q8, 24'h0};
        end else if (q == 4'd9) begin
          gen_w0 = win[0] ^ {RCON_FIX_Q9, 24'h0};
        end else begin
          gen_rcon_idx = q[2:0];
        end
      end
    end
  end

  // Round-key file write selection. With a single write port, the second
  // AES-256 key half (rk1) is written during START rather than at load.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    case (state)
      ST_IDLE: begin
        if (key_load && !clear) begin
          wr_en   = 1'b1;
          wr_idx  = 4'd0;
          wr_data = key_in[255:128];
        end
      end
      ST_START: begin
        if (mode && (q == 4'd0)) begin
          wr_en   = 1'b1;
          wr_idx  = 4'd1;
          wr_data = win[4:7];
        end
      end
      ST_WAIT: begin
        if (gen_done) begin
          wr_en   = 1'b1;
          wr_idx  = q + (mode ? 4'd2 : 4'd1);
          wr_data = result;
        end
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
  end

  aes_rk_file u_rk_file (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .rd_en     (rk_rd_en),
    .rd_idx    (rk_rd_idx),
    .rd_last   (last_rk_idx(mode)),
    .clear_all (clear),
    .rd_data   (rk_rd_data)
  );

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl: behavioural generator model,
// FIPS-197 key-expansion reference, directed and randomized runs.
// Zeroize steps are built when AES_KEYSCHED_ZEROIZE_EN is defined.
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] key_in = '0;
  logic         key_mode = 1'b0;
  logic         key_load = 1'b0;
  logic         busy, key_ready;
  logic [31:0]  gen_w0, gen_w1, gen_w2, gen_w3, gen_w4, gen_w5, gen_w6, gen_w7;
  logic [2:0]   gen_rcon_idx;
  logic         gen_use_rcon, gen_start;
  logic [31:0]  gen_w8, gen_w9, gen_w10, gen_w11;
  logic         gen_done;
  logic         rk_rd_en = 1'b0;
  logic [3:0]   rk_rd_idx = '0;
  logic [127:0] rk_rd_data;
`ifdef AES_KEYSCHED_ZEROIZE_EN
  logic         key_clear = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] exp_rk [15];
  logic         cur_mode = 1'b0;

  logic [3:0]   g_cnt;
  logic [127:0] g_res;
  logic         outstanding, prev_start;

  localparam logic [127:0] K128   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K128_1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] K256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  always #5 clk = ~clk;

  aes_key_sched_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_in       (key_in),
    .key_mode     (key_mode),
    .key_load     (key_load),
    .busy         (busy),
    .key_ready    (key_ready),
    .gen_w0       (gen_w0),
    .gen_w1       (gen_w1),
    .gen_w2       (gen_w2),
    .gen_w3       (gen_w3),
    .gen_w4       (gen_w4),
    .gen_w5       (gen_w5),
    .gen_w6       (gen_w6),
    .gen_w7       (gen_w7),
    .gen_rcon_idx (gen_rcon_idx),
    .gen_use_rcon (gen_use_rcon),
    .gen_start    (gen_start),
    .gen_w8       (gen_w8),
    .gen_w9       (gen_w9),
    .gen_w10      (gen_w10),
    .gen_w11      (gen_w11),
    .gen_done     (gen_done),
    .rk_rd_en     (rk_rd_en),
    .rk_rd_idx    (rk_rd_idx),
    .rk_rd_data   (rk_rd_data)
`ifdef AES_KEYSCHED_ZEROIZE_EN
    ,
    .key_clear    (key_clear)
`endif
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [31:0] rotword(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Single-lane generator behaviour: next four words from the window.
  function automatic logic [127:0] gen_model(input logic [31:0] a0, input logic [31:0] a1,
                                             input logic [31:0] a2, input logic [31:0] a3,
                                             input logic [31:0] a7, input logic use_rc,
                                             input logic [2:0] idx);
    logic [31:0] t, b0, b1, b2, b3;
    logic [7:0]  rc;
    rc = 8'h01;
    rc = rc << idx;
    t  = use_rc ? (subword(rotword(a7)) ^ {rc, 24'h0}) : subword(a7);
    b0 = a0 ^ t;
    b1 = a1 ^ b0;
    b2 = a2 ^ b1;
    b3 = a3 ^ b2;
    return {b0, b1, b2, b3};
  endfunction

  // FIPS-197 key expansion into exp_rk; entries past the last round are 0.
  task automatic ref_expand(input logic [255:0] key, input logic mode);
    logic [31:0]  w [60];
    logic [255:0] k;
    logic [31:0]  t;
    logic [7:0]   rc;
    int nk, nr;
    nk = mode ? 8 : 4;
    nr = mode ? 14 : 10;
    rc = 8'h01;
    k  = key;
    for (int i = 0; i < nk; i++) begin
      w[i] = k[255:224];
      k = k << 32;
    end
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subword(rotword(t)) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if ((nk == 8) && (i % nk == 4)) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 15; r++) begin
      if (r <= nr) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else         exp_rk[r] = '0;
    end
  endtask

  // Generator stand-in: 9-cycle latency, reset by the shared rst_n.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_cnt       <= '0;
      gen_done    <= 1'b0;
      g_res       <= '0;
      outstanding <= 1'b0;
      prev_start  <= 1'b0;
    end else begin
      prev_start <= gen_start;
      gen_done   <= (g_cnt == 4'd1) && !gen_start;
      if (gen_start) begin
        g_cnt       <= 4'd8;
        g_res       <= gen_model(gen_w0, gen_w1, gen_w2, gen_w3, gen_w7,
                                 gen_use_rcon, gen_rcon_idx);
        outstanding <= 1'b1;
      end else begin
        if (g_cnt != 4'd0) g_cnt <= g_cnt - 4'd1;
        if (gen_done) outstanding <= 1'b0;
      end
    end
  end

  assign {gen_w8, gen_w9, gen_w10, gen_w11} = g_res;

  // Launch-protocol and AES-128 window-duplication monitor.
  always @(negedge clk) begin
    if (rst_n && gen_start) begin
      checks++;
      assert (!prev_start && !outstanding) else begin
        errors++;
        $error("FAIL gen_start_overlap: prev=%0b outstanding=%0b required 0 0",
               prev_start, outstanding);
      end
      if (!cur_mode) begin
        checks++;
        assert ({gen_w4[23:0], gen_w5, gen_w6, gen_w7} === {gen_w0[23:0], gen_w1, gen_w2, gen_w3})
        else begin
          errors++;
          $error("FAIL aes128_window_dup: w4..7=%h required %h",
                 {gen_w4[23:0], gen_w5, gen_w6, gen_w7}, {gen_w0[23:0], gen_w1, gen_w2, gen_w3});
        end
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [255:0] k, input logic m);
    key_in   = k;
    key_mode = m;
    key_load = 1'b1;
    cur_mode = m;
    tick();
    key_load = 1'b0;
  endtask

  task automatic wait_ready(input int start, output int cyc);
    cyc = start;
    while (!key_ready && (cyc < 400)) begin
      tick();
      cyc++;
    end
  endtask

  task automatic rd_expect(input logic [3:0] idx, input logic [127:0] exp, input string tag);
    rk_rd_en  = 1'b1;
    rk_rd_idx = idx;
    tick();
    rk_rd_en  = 1'b0;
    check($sformatf("%s[%0d]", tag, idx), rk_rd_data, exp);
  endtask

  task automatic rd_all(input string tag);
    logic [3:0] idx;
    for (int i = 0; i < 16; i++) begin
      idx = 4'(i);
      if (i < 15) rd_expect(idx, exp_rk[i], tag);
      else        rd_expect(idx, '0, tag);
    end
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    int cyc;
    logic [255:0] k;
    logic         m;

    for (int x = 0; x < 256; x++) begin
      logic [7:0] b, r;
      r = 8'h01;
      for (int j = 0; j < 254; j++) r = gmul(r, 8'(x));
      b = r;
      sbox_t[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                    ^ {b[3:0], b[7:4]} ^ 8'h63;
    end

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 128'(busy), '0);
    check("rst_key_ready", 128'(key_ready), '0);
    check("rst_gen_start", 128'(gen_start), '0);
    check("rst_rcon", 128'({gen_use_rcon, gen_rcon_idx}), '0);
    check("rst_window", {gen_w0, gen_w3, gen_w4, gen_w7}, '0);
    check("rst_rd_data", rk_rd_data, '0);
    rst_n = 1'b1;
    tick();

    // AES-128 FIPS-197 vector; the ignored low half is random.
    k = {K128, $urandom(), $urandom(), $urandom(), $urandom()};
    ref_expand(k, 1'b0);
    do_load(k, 1'b0);
    check("a128_busy_c1", 128'(busy), 128'd1);
    wait_ready(1, cyc);
    check("a128_ready_cycle", 128'(cyc), 128'd101);
    check("a128_busy_done", 128'(busy), '0);
    rd_expect(4'd1, K128_1, "a128_rk1_const");
    rd_expect(4'd10, K128_10, "a128_rk10_const");
    rd_all("a128_rk");

    // key_load while busy at cycle 40 is ignored.
    do_load(k, 1'b0);
    repeat (39) tick();
    key_in   = rand_key();
    key_mode = 1'b1;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    wait_ready(41, cyc);
    check("busyload_ready_cycle", 128'(cyc), 128'd101);
    rd_expect(4'd10, K128_10, "busyload_rk10_const");
    rd_all("busyload_rk");

    // Read-port bounds with the AES-128 key loaded.
    rd_expect(4'd11, '0, "bound_idx11");
    rd_expect(4'd15, '0, "bound_idx15");
    rd_expect(4'd0, K128, "bound_idx0");

    // AES-256 FIPS-197 vector; also a restart from key_ready.
    ref_expand(K256, 1'b1);
    do_load(K256, 1'b1);
    check("restart_ready_low", 128'(key_ready), '0);
    check("restart_busy", 128'(busy), 128'd1);
    wait_ready(1, cyc);
    check("a256_ready_cycle", 128'(cyc), 128'd131);
    rd_expect(4'd14, K256_14, "a256_rk14_const");
    rd_all("a256_rk");

    // Randomized keys and modes.
    for (int n = 0; n < 6; n++) begin
      k = rand_key();
      m = 1'(n % 2 == 0 ? $urandom_range(0, 1) : (n / 2) % 2);
      ref_expand(k, m);
      do_load(k, m);
      wait_ready(1, cyc);
      check($sformatf("rand%0d_ready_cycle", n), 128'(cyc), m ? 128'd131 : 128'd101);
      rd_all($sformatf("rand%0d_rk", n));
    end

    // Reset asserted at cycle 55 of an AES-128 run.
    do_load(rand_key(), 1'b0);
    repeat (54) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", 128'({busy, key_ready, gen_start, gen_use_rcon, gen_rcon_idx}), '0);
    check("midrst_window", {gen_w0, gen_w2, gen_w5, gen_w7}, '0);
    check("midrst_rd_data", rk_rd_data, '0);
    tick();
    rst_n = 1'b1;
    tick();
    rd_expect(4'd0, '0, "midrst_rd");
    rd_expect(4'd4, '0, "midrst_rd");
    rd_expect(4'd10, '0, "midrst_rd");
    k = rand_key();
    ref_expand(k, 1'b1);
    do_load(k, 1'b1);
    wait_ready(1, cyc);
    check("postrst_ready_cycle", 128'(cyc), 128'd131);
    rd_all("postrst_rk");

`ifdef AES_KEYSCHED_ZEROIZE_EN
    // Zeroize at cycle 25: drain the outstanding quartet, file reads zero.
    do_load(K256, 1'b0);
    repeat (24) tick();
    key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
    check("zero_busy_drain", 128'(busy), 128'd1);
    check("zero_ready_low", 128'(key_ready), '0);
    check("zero_rd_data", rk_rd_data, '0);
    cyc = 26;
    while (busy && (cyc < 400)) begin
      tick();
      cyc++;
    end
    check("zero_idle_cycle", 128'(cyc), 128'd31);
    for (int i = 0; i < 15; i++) rd_expect(4'(i), '0, "zero_rd");
    check("zero_ready_stays", 128'(key_ready), '0);
    ref_expand({K128, 128'h0}, 1'b0);
    do_load({K128, 128'h0}, 1'b0);
    wait_ready(1, cyc);
    check("zero_reload_ready_cycle", 128'(cyc), 128'd101);
    rd_all("zero_reload_rk");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
